// File: rtl/io_hub_pkg.sv
// io_hub_pkg: shared constants for the I/O hub.
// Holds the device select codes, per-device register offsets and the
// default debounce length. Imported by io_hub and io_hub_debounce.
package io_hub_pkg;
    localparam logic [2:0] DEV_LED = 3'd0;
    localparam logic [2:0] DEV_SW  = 3'd1;
    localparam logic [2:0] DEV_BTN = 3'd2;

    localparam logic [1:0] LED_VAL = 2'd0;
    localparam logic [1:0] LED_SET = 2'd1;
    localparam logic [1:0] LED_CLR = 2'd2;
    localparam logic [1:0] LED_TGL = 2'd3;

    localparam logic [1:0] SW_VAL = 2'd0;
    localparam logic [1:0] SW_CHG = 2'd1;

    localparam logic [1:0] BTN_LVL  = 2'd0;
    localparam logic [1:0] BTN_PEND = 2'd1;
    localparam logic [1:0] BTN_CNT  = 2'd2;
    localparam logic [1:0] BTN_MASK = 2'd3;

    localparam int DEFAULT_DEB_CYCLES = 16;
endpackage

// File: rtl/io_hub_if.sv
// io_hub_if: CPU-side I/O bus of the hub.
// Signals: dev_sel (device), reg_sel (register), we (write strobe),
// data_in (write data), data_out (combinational read data).
// master = CPU side, slave = hub side.
interface io_hub_if #(
    parameter int DATA_W = 16
);
    logic [2:0]        dev_sel;
    logic [1:0]        reg_sel;
    logic              we;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;

    modport master (output dev_sel, reg_sel, we, data_in, input data_out);
    modport slave  (input dev_sel, reg_sel, we, data_in, output data_out);
endinterface

// File: rtl/io_hub_debounce.sv
// io_hub_debounce: one-bit 2-flop synchroniser plus debounce filter.
// Ports: clk, reset (sync, active-high), din (raw async pin),
// level (stable value), rise/fall (one-cycle pulses in the first cycle
// the stable value shows its new level).
// Macro IO_HUB_DEBOUNCE_EN: when defined, the stable value only follows
// the synchronised input after DEB_CYCLES consecutive differing cycles;
// when undefined, the stable value is the synchroniser output.
module io_hub_debounce
    import io_hub_pkg::*;
#(
    parameter int DEB_CYCLES = DEFAULT_DEB_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic s1, s2, stable, stable_q;

`ifdef IO_HUB_DEBOUNCE_EN
    localparam int CW = DEB_CYCLES > 1 ? $clog2(DEB_CYCLES) : 1;
    logic [CW-1:0] cnt;

    // Counter runs only while the synchronised input disagrees with the
    // stable value; any agreement restarts the count, so short glitches die.
    always_ff @(posedge clk) begin
        if (reset) begin
            {s1, s2, stable, stable_q} <= '0;
            cnt <= '0;
        end else begin
            s1       <= din;
            s2       <= s1;
            stable_q <= stable;
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
`else
    localparam int unused_deb = DEB_CYCLES;

    always_ff @(posedge clk) begin
        if (reset) begin
            {s1, s2, stable_q} <= '0;
        end else begin
            s1       <= din;
            s2       <= s1;
            stable_q <= stable;
        end
    end

    assign stable = s2;
`endif

    assign level = stable;
    assign rise  = stable & ~stable_q;
    assign fall  = ~stable & stable_q;
endmodule

// File: rtl/io_hub.sv
// io_hub: memory-mapped LED/switch/button hub on the CPU I/O bus.
// Ports: clk, reset (sync, active-high), bus (io_hub_if slave: dev_sel,
// reg_sel, we, data_in, data_out), Led (LED drive), sw/btn (raw async
// pins), irq (registered, OR of pending & mask).
// Macro IO_HUB_DEBOUNCE_EN selects debounced inputs (see io_hub_debounce).
module io_hub
    import io_hub_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int NUM_LED    = 8,
    parameter int NUM_SW     = 8,
    parameter int NUM_BTN    = 4,
    parameter int DEB_CYCLES = DEFAULT_DEB_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    io_hub_if.slave            bus,
    output logic [NUM_LED-1:0] Led,
    input  logic [NUM_SW-1:0]  sw,
    input  logic [NUM_BTN-1:0] btn,
    output logic               irq
);
    logic [NUM_SW-1:0]  sw_lvl, sw_rise, sw_fall, sw_chg;
    logic [NUM_BTN-1:0] btn_lvl, btn_rise, btn_fall, btn_pend, btn_mask;
    logic [NUM_LED-1:0] led_q, led_d, led_din;
    logic [DATA_W-1:0]  press_cnt;
    logic               wr_led, wr_sw, wr_btn;
    logic               unused_bits;

    genvar i;
    for (i = 0; i < NUM_SW; i++) begin : g_sw
        io_hub_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk(clk), .reset(reset), .din(sw[i]),
            .level(sw_lvl[i]), .rise(sw_rise[i]), .fall(sw_fall[i])
        );
    end
    for (i = 0; i < NUM_BTN; i++) begin : g_btn
        io_hub_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk(clk), .reset(reset), .din(btn[i]),
            .level(btn_lvl[i]), .rise(btn_rise[i]), .fall(btn_fall[i])
        );
    end

    assign unused_bits = ^{btn_fall, bus.data_in};

    assign wr_led  = bus.we && bus.dev_sel == DEV_LED;
    assign wr_sw   = bus.we && bus.dev_sel == DEV_SW;
    assign wr_btn  = bus.we && bus.dev_sel == DEV_BTN;
    assign led_din = bus.data_in[NUM_LED-1:0];

    always_comb begin
        led_d = !wr_led                ? led_q :
                bus.reg_sel == LED_VAL ? led_din :
                bus.reg_sel == LED_SET ? led_q | led_din :
                bus.reg_sel == LED_CLR ? led_q & ~led_din :
                                         led_q ^ led_din;
    end

    // New edges are ORed in after the W1C mask so an edge always wins,
    // and the counter clear is applied before the increment so a
    // coinciding press still counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            led_q     <= '0;
            sw_chg    <= '0;
            btn_pend  <= '0;
            btn_mask  <= '0;
            press_cnt <= '0;
            irq       <= 1'b0;
        end else begin
            led_q     <= led_d;
            sw_chg    <= (sw_chg & ~(wr_sw && bus.reg_sel == SW_CHG ? bus.data_in[NUM_SW-1:0] : '0))
                         | sw_rise | sw_fall;
            btn_pend  <= (btn_pend & ~(wr_btn && bus.reg_sel == BTN_PEND ? bus.data_in[NUM_BTN-1:0] : '0))
                         | btn_rise;
            btn_mask  <= wr_btn && bus.reg_sel == BTN_MASK ? bus.data_in[NUM_BTN-1:0] : btn_mask;
            press_cnt <= (wr_btn && bus.reg_sel == BTN_CNT ? '0 : press_cnt) + DATA_W'(|btn_rise);
            irq       <= |(btn_pend & btn_mask);
        end
    end

    assign Led = led_q;

    assign bus.data_out =
        bus.dev_sel == DEV_LED ? DATA_W'(led_q) :
        bus.dev_sel == DEV_SW  ? (bus.reg_sel == SW_VAL ? DATA_W'(sw_lvl) :
                                  bus.reg_sel == SW_CHG ? DATA_W'(sw_chg) : '0) :
        bus.dev_sel == DEV_BTN ? (bus.reg_sel == BTN_LVL  ? DATA_W'(btn_lvl) :
                                  bus.reg_sel == BTN_PEND ? DATA_W'(btn_pend) :
                                  bus.reg_sel == BTN_CNT  ? press_cnt :
                                                            DATA_W'(btn_mask)) :
        '0;
endmodule

// File: doc/io_hub.md
# io_hub

Parametrised memory-mapped I/O hub for the simple machine's I/O port, the next generation of the LED/switch/button decoder. It decodes `dev_sel`/`reg_sel` into per-device register banks and drives an LED register with set/clear/toggle access. Switch and button inputs are synchronised and debounced. Button presses are captured as sticky pending flags with a maskable interrupt, and a press counter is provided. It sits between the CPU's I/O bus and the board pins.

## Interface
- `DATA_W`, 16, bus data width.
- `NUM_LED`, 8, LED outputs; must be ≤ `DATA_W`.
- `NUM_SW`, 8, switch inputs; must be ≤ `DATA_W`.
- `NUM_BTN`, 4, button inputs; must be ≤ `DATA_W`.
- `DEB_CYCLES`, 16, stable cycles required before a debounced value changes; must be ≥ 1.
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `dev_sel`  in  3  device select: 0 LED, 1 switches, 2 buttons, 3–7 reserved.
- `reg_sel`  in  2  register select within the device.
- `we`  in  1  write strobe; one write per asserted cycle.
- `data_in`  in  `DATA_W`  write data.
- `data_out`  out  `DATA_W`  combinational read data.
- `Led`  out  `NUM_LED`  LED drive, taken directly from the LED register.
- `sw`  in  `NUM_SW`  raw asynchronous switches.
- `btn`  in  `NUM_BTN`  raw asynchronous buttons.
- `irq`  out  1  registered; equals `|(btn_pend & btn_mask)`.

## Operation
- Register map by `dev_sel`/`reg_sel`. Reads are side-effect free. Reads zero-extend to `DATA_W`; writes ignore bits above the device width. Writes to read-only or reserved locations are ignored, and those locations read 0.
- LED device (0):
  - reg 0: R/W value.
  - reg 1: write ORs `data_in` into the value (set).
  - reg 2: write clears the bits set in `data_in` (clear).
  - reg 3: write XORs `data_in` into the value (toggle).
  - regs 1–3 read back the value.
- Switch device (1):
  - reg 0: debounced switch value (RO).
  - reg 1: `sw_chg` sticky flags, set on any debounced edge. Writing a 1 clears the corresponding flag (W1C).
  - regs 2–3: read 0.
- Button device (2):
  - reg 0: debounced level (RO).
  - reg 1: `btn_pend`, set on a debounced rising edge; W1C.
  - reg 2: `press_cnt`, `DATA_W`-bit wrapping counter. It increments by exactly 1 in any cycle with ≥1 new rising edge, regardless of how many buttons rose. Any write clears it.
  - reg 3: `btn_mask`, R/W.
- Per-input filter: 2-flop synchroniser. The debounce counter resets whenever the synchronised value equals the stable value. Otherwise it increments; when it reaches `DEB_CYCLES`-1, the stable value takes the synchronised value and the counter resets. A glitch shorter than `DEB_CYCLES` cycles never changes the stable value.
- Simultaneous events:
  - W1C and a new edge on the same bit in the same cycle: the flag ends set.
  - Counter clear and an increment in the same cycle: counter ends at 1.
  - Counter at all-ones plus a press: counter wraps to 0.
- Reset values:
  - LED value, `sw_chg`, `btn_pend`, `btn_mask`, `press_cnt`, debounce counters, synchronisers and stable values: all 0.
  - `irq` and `Led`: 0.
  - A press in progress when reset is asserted is discarded.

## Timing
- Writes take effect on the rising edge where `we`=1. `Led` reflects the write one cycle later.
- `data_out` is combinational from the select inputs and register state, with no added latency. A read in the same cycle as a write returns the old value.
- Pin-to-stable latency: 2 synchroniser cycles + `DEB_CYCLES` cycles.
- A sticky flag becomes visible in the cycle after the stable value changes.
- `irq` lags flag or mask changes by 1 cycle.

## Configuration
- `IO_HUB_DEBOUNCE_EN` defined: debounce counters are present as described.
- `IO_HUB_DEBOUNCE_EN` undefined:
  - The stable value is the synchroniser output; pin-to-stable latency is 2 cycles.
  - No counters are built and `DEB_CYCLES` is ignored.
  - Register map and flag behaviour are unchanged.

## Structure
- `io_hub_pkg` holds:
  - device select constants `DEV_LED`=0, `DEV_SW`=1, `DEV_BTN`=2;
  - register offset constants per device;
  - `DEFAULT_DEB_CYCLES`.
- Sub-module `io_hub_debounce`: one bit of synchroniser plus debounce, honouring `IO_HUB_DEBOUNCE_EN`. Outputs the stable level and a one-cycle rise and fall pulse. It is instantiated per switch and per button through generate loops.

## Test plan
- After reset: `Led`=0 and `irq`=0. Reads of dev 0/1/2 reg 1 all return 0. Reads of dev 5 return 0 even after a write to dev 5.
- LED: write 0x00F0 to reg 0, set 0x0003, clear 0x0010, toggle 0x0081. Expect `Led`=0x0062 and a reg 0 read of 0x0062.
- Debounce (`DEB_CYCLES`=16): a 10-cycle glitch on `sw[2]` leaves reg 0 = 0. Holding it high gives reg 0 = 0x0004 exactly 18 cycles after the pin change, and `sw_chg`=0x0004. W1C of 0x0004 returns `sw_chg` to 0.
- Buttons: set `btn_mask`=0x0002 and press `btn[0]`: `btn_pend`=0x0001, `irq` stays 0, `press_cnt`=1. Press `btn[1]`: `irq`=1 one cycle after the flag sets. W1C 0x0002 in the same cycle as a new `btn[1]` edge: the flag stays set.
- Counter: with `press_cnt` preloaded to 0xFFFF by 65535 presses (or forced), one more press gives 0. A write to reg 2 coinciding with a press gives 1.
- Mid-operation reset: assert `reset` while the `btn[3]` debounce counter is at 8. After release with the pin still high, a full 2+`DEB_CYCLES` latency elapses before `btn_pend[3]` sets.
